program_sequencer: RTL

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/picomips_pkg.sv | 24 ++
 rtl/return_stack.sv | 45 ++++
 rtl/program_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/picomips_pkg.sv
// Shared types and constants for the picoMIPS program-address path.
package picomips_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_REL,
        OP_ABS,
        OP_CALL,
        OP_RET
    } pc_op_t;

    // Raw sequencing requests, highest priority in the MSB.
    typedef struct packed {
        logic ret;
        logic call;
        logic branch_abs;
        logic branch_rel;
        logic pc_inc;
    } pc_req_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; the top entry is readable in the cycle right after a push.
module return_stack #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 4
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic [$clog2(D+1)-1:0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned LW = $clog2(D + 1);
    localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem [D];
    logic [LW-1:0] level_q;

    assign full  = (level_q == LW'(D));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign top   = empty ? '0 : mem[IW'(level_q - LW'(1))];

    // Entry storage needs no reset; only the level defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[IW'(level_q)] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            level_q <= '0;
        end else if (push && !full) begin
            level_q <= level_q + LW'(1);
        end else if (pop && !empty) begin
            level_q <= level_q - LW'(1);
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter with prioritized inc/branch/jump/call/return and a return-address stack.
module program_sequencer
    import picomips_pkg::*;
#(
    parameter int unsigned                   program_code_size = PC_WIDTH_DEFAULT,
    parameter int unsigned                   stack_depth       = 4,
    parameter logic [program_code_size-1:0]  reset_vector      = '0
) (
    input  logic                                 clk,
    input  logic                                 n_reset,
    input  logic                                 pc_inc,
    input  logic                                 branch_rel,
    input  logic                                 branch_abs,
    input  logic                                 call,
    input  logic                                 ret,
    input  logic [program_code_size-1:0]         branch_offset,
    input  logic [program_code_size-1:0]         branch_target,
    output logic [program_code_size-1:0]         pc_out,
    output logic [$clog2(stack_depth+1)-1:0]     stack_level,
    output logic                                 stack_overflow,
    output logic                                 stack_underflow
);

    localparam int unsigned W = program_code_size;

    pc_req_t      req;
    pc_op_t       op;
    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;
    logic [W-1:0] stack_top;
    logic [W-1:0] pc_plus_one;
    logic         stack_full;
    logic         stack_empty;
    logic         push;
    logic         pop;
    logic         overflow_q;
    logic         underflow_q;

    assign req         = {ret, call, branch_abs, branch_rel, pc_inc};
    assign pc_plus_one = pc_q + W'(1);

    // Fixed-priority decode; losing requests are simply dropped.
    always_comb begin
        op = OP_HOLD;
        if (req.ret) begin
            op = OP_RET;
        end else if (req.call) begin
            op = OP_CALL;
        end else if (req.branch_abs) begin
            op = OP_ABS;
        end else if (req.branch_rel) begin
            op = OP_REL;
        end else if (req.pc_inc) begin
            op = OP_INC;
        end
    end

    // Modulo-2^W arithmetic makes the W-bit add equal to a sign-extended offset add.
    always_comb begin
        pc_d = pc_q;
        push = 1'b0;
        pop  = 1'b0;
        case (op)
            OP_INC:  pc_d = pc_plus_one;
            OP_REL:  pc_d = pc_q + branch_offset;
            OP_ABS:  pc_d = branch_target;
            OP_CALL: begin
                pc_d = branch_target;
                push = !stack_full;
            end
            OP_RET: begin
                if (!stack_empty) begin
                    pc_d = stack_top;
                    pop  = 1'b1;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pc_q        <= reset_vector;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            overflow_q  <= overflow_q  | ((op == OP_CALL) && stack_full);
            underflow_q <= underflow_q | ((op == OP_RET) && stack_empty);
        end
    end

    return_stack #(
        .W (W),
        .D (stack_depth)
    ) u_return_stack (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus_one),
        .top       (stack_top),
        .level     (stack_level),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign pc_out          = pc_q;
    assign stack_overflow  = overflow_q;
    assign stack_underflow = underflow_q;

endmodule
